// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: data width, bubble word and fetch FSM encoding.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // A fetch PC is unusable when it is not word aligned or lies beyond imem.
  function automatic logic pc_is_bad(input logic [XLEN-1:0] pc, input int unsigned aw);
    logic [XLEN-1:0] upper;
    upper = pc >> (aw + 2);
    return (pc[1:0] != 2'b00) || (upper != '0);
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem and fills the IF/ID register,
// honouring stall, EX redirect and sticky misaligned/out-of-range fetch faults.
//
// state    | meaning
// ST_BOOT  | first cycle after reset release; PC held, IF/ID bubble
// ST_RUN   | normal fetch with redirect > stall > fetch priority
// ST_FAULT | bad PC seen; IF/ID bubble every cycle until redirect to a good PC
module if_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     IMEM_AW   = 7,
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  output logic [XLEN-1:0]    if_id_instr,
  output logic [XLEN-1:0]    if_id_pc4,
  output logic               if_id_valid,
  output logic [XLEN-1:0]    pc,
  output logic               fetch_fault,
  output logic [XLEN-1:0]    fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            pc_bad;
  logic            target_bad;
  logic            bubble;
  logic [XLEN-1:0] pc_plus4;

  assign pc_bad     = pc_is_bad(pc_q, IMEM_AW);
  assign target_bad = pc_is_bad(redirect_pc, IMEM_AW);
  assign pc_plus4   = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    bubble  = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        bubble  = 1'b1;
        state_d = pc_bad ? ST_FAULT : ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          // A bad target is accepted here and trips the fault on the next evaluation.
          pc_d   = redirect_pc;
          bubble = 1'b1;
        end else if (stall) begin
          bubble = 1'b0;
        end else if (pc_bad) begin
          state_d = ST_FAULT;
          bubble  = 1'b1;
        end else begin
          instr_d = imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          count_d = count_q + 32'd1;
        end
      end
      ST_FAULT: begin
        bubble = 1'b1;
        if (redirect) begin
          pc_d = redirect_pc;
          if (!target_bad) state_d = ST_RUN;
        end
      end
      default: begin
        bubble  = 1'b1;
        state_d = ST_FAULT;
      end
    endcase

    if (bubble) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign pc          = pc_q;
  assign fetch_fault = (state_q == ST_FAULT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized bench for if_stage against a cycle-level behavioural fetch model.
module tb_if_stage;
  import mips_pkg::*;

  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   if_id_instr;
  logic [31:0]   if_id_pc4;
  logic          if_id_valid;
  logic [31:0]   pc;
  logic          fetch_fault;
  logic [31:0]   fetch_count;

  logic [31:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  bit          m_valid, m_boot, m_fault;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (AW),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .if_id_instr(if_id_instr),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid),
    .pc         (pc),
    .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  function automatic bit good_pc(input logic [31:0] p);
    return (p % 4 == 0) && (p < 4 * DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
    m_valid = 0; m_boot = 1; m_fault = 0;
  endtask

  task automatic model_bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
  endtask

  task automatic model_edge();
    if (m_boot) begin
      m_boot = 0;
      m_fault = !good_pc(m_pc);
      model_bubble();
    end else if (m_fault) begin
      model_bubble();
      if (redirect) begin
        m_pc = redirect_pc;
        m_fault = !good_pc(redirect_pc);
      end
    end else if (redirect) begin
      m_pc = redirect_pc;
      model_bubble();
    end else if (stall) begin
      // everything holds
    end else if (!good_pc(m_pc)) begin
      m_fault = 1;
      model_bubble();
    end else begin
      m_instr = mem[(m_pc / 4) % DEPTH];
      m_pc4   = m_pc + 4;
      m_valid = 1;
      m_pc    = m_pc + 4;
      m_count = m_count + 1;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".pc"},    pc,                   m_pc);
    chk({ph, ".addr"},  32'(imem_addr),       (m_pc / 4) % DEPTH);
    chk({ph, ".instr"}, if_id_instr,          m_instr);
    chk({ph, ".pc4"},   if_id_pc4,            m_pc4);
    chk({ph, ".valid"}, 32'(if_id_valid),     32'(m_valid));
    chk({ph, ".fault"}, 32'(fetch_fault),     32'(m_fault));
    chk({ph, ".count"}, fetch_count,          m_count);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003; mem[3] = 32'hDDDD_0004;

    // reset and boot
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("boot");
    chk("boot_valid", 32'(if_id_valid), 32'd0);

    // sequential fetch with a two-cycle stall while IF/ID holds B
    step("fetchA");
    chk("t1_A", if_id_instr, 32'hAAAA_0001);
    chk("t1_A_pc4", if_id_pc4, 32'd4);
    step("fetchB");
    stall = 1'b1;
    step("stall1");
    step("stall2");
    chk("t2_hold_instr", if_id_instr, 32'hBBBB_0002);
    chk("t2_hold_pc", pc, 32'd8);
    stall = 1'b0;
    step("fetchC");
    chk("t2_C", if_id_instr, 32'hCCCC_0003);
    step("fetchD");
    chk("t1_D_pc4", if_id_pc4, 32'd16);
    chk("t1_count", fetch_count, 32'd4);

    // redirect overrides stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step("redir40");
    chk("t3_pc", pc, 32'h40);
    chk("t3_valid", 32'(if_id_valid), 32'd0);
    stall = 1'b0; redirect = 1'b0;
    step("after40");
    chk("t3_instr", if_id_instr, mem[16]);

    // misaligned redirect then recovery
    redirect = 1'b1; redirect_pc = 32'h42;
    step("redir42");
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) step("fault_hold");
    chk("t4_fault", 32'(fetch_fault), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h10;
    step("recover10");
    chk("t4_clear", 32'(fetch_fault), 32'd0);
    redirect = 1'b0;
    step("after10");
    chk("t4_instr", if_id_instr, mem[4]);

    // run off the top of imem
    redirect = 1'b1; redirect_pc = 32'h1F0;
    step("redir1F0");
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) step("top_run");
    chk("t5_last", if_id_instr, mem[127]);
    chk("t5_pc", pc, 32'h200);
    step("top_fault");
    chk("t5_fault", 32'(fetch_fault), 32'd1);
    step("top_hold");
    chk("t5_novalid", 32'(if_id_valid), 32'd0);

    // recover, run, then async reset between edges
    redirect = 1'b1; redirect_pc = 32'h0;
    step("redir0");
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) step("pre_rst");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    chk("t6_count", fetch_count, 32'd0);
    @(posedge clk); #1;
    check_all("rst_hold");
    rst_n = 1'b1;
    step("boot2");
    step("post_rst");
    chk("t6_instr", if_id_instr, 32'hAAAA_0001);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      redirect = m_fault ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = ($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
        2:       redirect_pc = 32'(4 * DEPTH - 4 * $urandom_range(1, 3));
        default: redirect_pc = $urandom_range(0, DEPTH - 1) * 4;
      endcase
      step("rand");
    end
    stall = 1'b0; redirect = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
